// File: rtl/reg_writeback_queue.sv
// Register file write-back queue: buffers write requests in a FIFO, drains
// one per granted cycle to the write port, and flags pending-write hazards.
// Ports: clk, reset (async, high); In_valid/In_ready/In_dest/ALU_result/
//   Mem_data/MemtoReg (request side); Port_grant, RegWrite, Write_register,
//   Write_data (register file side); Read_register1/2 -> Hazard1/2; Count.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [ADDR_W-1:0] In_dest,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] Mem_data,
  input  logic              MemtoReg,
  input  logic              Port_grant,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] Read_register1,
  input  logic [ADDR_W-1:0] Read_register2,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic [CW-1:0]     Count
);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic push, store, pop;
  logic [DEPTH-1:0] live;
  logic match1, match2;

  assign In_ready = (count_q < CW'(DEPTH));
  assign push     = In_valid && In_ready;
  // r0 writes complete the handshake but are never stored
  assign store    = push && (In_dest != '0);
  assign pop      = Port_grant && (count_q != '0);

  always_comb begin
    dest_d   = dest_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(store) - CW'(pop);
    regwrite_d = pop;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    if (store) begin
      dest_d[wr_ptr_q] = In_dest;
      data_d[wr_ptr_q] = MemtoReg ? Mem_data : ALU_result;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      wreg_d   = dest_q[rd_ptr_q];
      wdata_d  = data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // An entry is live when its distance from the read pointer is below Count
  always_comb begin
    live   = '0;
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = CW'(PW'(i) - rd_ptr_q) < count_q;
      if (live[i] && dest_q[i] == Read_register1) match1 = 1'b1;
      if (live[i] && dest_q[i] == Read_register2) match2 = 1'b1;
    end
    if (regwrite_q && wreg_q == Read_register1) match1 = 1'b1;
    if (regwrite_q && wreg_q == Read_register2) match2 = 1'b1;
  end

  assign Hazard1 = (Read_register1 != '0) && match1;
  assign Hazard2 = (Read_register2 != '0) && match2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      dest_q     <= dest_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite       = regwrite_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;
  assign Count          = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        In_valid;
  logic        In_ready;
  logic [4:0]  In_dest;
  logic [31:0] ALU_result;
  logic [31:0] Mem_data;
  logic        MemtoReg;
  logic        Port_grant;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [4:0]  Read_register1;
  logic [4:0]  Read_register2;
  logic        Hazard1;
  logic        Hazard2;
  logic [2:0]  Count;

  int n_cmp = 0;
  int n_err = 0;

  reg_writeback_queue dut (
    .clk(clk), .reset(reset),
    .In_valid(In_valid), .In_ready(In_ready), .In_dest(In_dest),
    .ALU_result(ALU_result), .Mem_data(Mem_data), .MemtoReg(MemtoReg),
    .Port_grant(Port_grant), .RegWrite(RegWrite),
    .Write_register(Write_register), .Write_data(Write_data),
    .Read_register1(Read_register1), .Read_register2(Read_register2),
    .Hazard1(Hazard1), .Hazard2(Hazard2), .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    In_valid = 0; In_dest = 0; ALU_result = 0; Mem_data = 0;
    MemtoReg = 0; Port_grant = 0;
    Read_register1 = 0; Read_register2 = 0;
    step();
    step();
    chk("rst_count", 32'(Count), 0);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_ready", 32'(In_ready), 1);
    chk("rst_wreg", 32'(Write_register), 0);
    chk("rst_wdata", Write_data, 0);
    chk("rst_haz1", 32'(Hazard1), 0);
    reset = 1'b0;
    step();

    // 1: ALU result, minimum latency
    In_valid = 1; In_dest = 3; ALU_result = 15; MemtoReg = 0;
    Port_grant = 1;
    step();
    In_valid = 0;
    chk("t1_count1", 32'(Count), 1);
    chk("t1_nobypass", 32'(RegWrite), 0);
    step();
    chk("t1_regwrite", 32'(RegWrite), 1);
    chk("t1_wreg", 32'(Write_register), 3);
    chk("t1_wdata", Write_data, 15);
    chk("t1_count0", 32'(Count), 0);
    step();
    chk("t1_pulse", 32'(RegWrite), 0);
    chk("t1_hold", 32'(Write_register), 3);

    // 2: memory data selected
    In_valid = 1; In_dest = 25; ALU_result = 7;
    Mem_data = 32'hDEADBEEF; MemtoReg = 1;
    step();
    In_valid = 0; MemtoReg = 0;
    step();
    chk("t2_regwrite", 32'(RegWrite), 1);
    chk("t2_wreg", 32'(Write_register), 25);
    chk("t2_wdata", Write_data, 32'hDEADBEEF);
    step();

    // 3: fill, full refusal, ordered drain
    Port_grant = 0;
    for (int i = 1; i <= 4; i++) begin
      In_valid = 1; In_dest = 5'(i); ALU_result = 100 + i;
      step();
    end
    In_valid = 0;
    chk("t3_full", 32'(Count), 4);
    chk("t3_ready0", 32'(In_ready), 0);
    In_valid = 1; In_dest = 9; ALU_result = 999;
    step();
    chk("t3_rejected", 32'(Count), 4);
    Port_grant = 1;
    #1;
    chk("t3_ready_pop", 32'(In_ready), 0);
    step();
    In_valid = 0;
    chk("t3_count3", 32'(Count), 3);
    chk("t3_w1_reg", 32'(Write_register), 1);
    chk("t3_w1_data", Write_data, 101);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("t3_wn_we", 32'(RegWrite), 1);
      chk("t3_wn_reg", 32'(Write_register), 32'(i));
      chk("t3_wn_data", Write_data, 32'(100 + i));
    end
    chk("t3_empty", 32'(Count), 0);
    step();
    chk("t3_idle", 32'(RegWrite), 0);

    // 4: r0 write dropped
    In_valid = 1; In_dest = 0; ALU_result = 55;
    #1;
    chk("t4_ready", 32'(In_ready), 1);
    step();
    In_valid = 0;
    chk("t4_count", 32'(Count), 0);
    chk("t4_we0", 32'(RegWrite), 0);
    step();
    chk("t4_we1", 32'(RegWrite), 0);
    Read_register1 = 0;
    #1;
    chk("t4_haz_r0", 32'(Hazard1), 0);

    // 5: hazards
    Port_grant = 0;
    In_valid = 1; In_dest = 20; ALU_result = 32'h20;
    step();
    In_valid = 0;
    Read_register1 = 20; Read_register2 = 21;
    #1;
    chk("t5_haz1", 32'(Hazard1), 1);
    chk("t5_haz2", 32'(Hazard2), 0);
    Read_register2 = 20;
    #1;
    chk("t5_haz2_hit", 32'(Hazard2), 1);
    Read_register2 = 21;
    Port_grant = 1;
    step();
    Port_grant = 0;
    chk("t5_we", 32'(RegWrite), 1);
    chk("t5_count", 32'(Count), 0);
    chk("t5_haz1_we", 32'(Hazard1), 1);
    step();
    chk("t5_haz1_drop", 32'(Hazard1), 0);

    // 6: reset mid-operation
    for (int i = 5; i <= 8; i++) begin
      In_valid = 1; In_dest = 5'(i); ALU_result = 200 + i;
      step();
    end
    In_valid = 0;
    Port_grant = 1;
    step();
    chk("t6_pre_we", 32'(RegWrite), 1);
    chk("t6_pre_count", 32'(Count), 3);
    Read_register1 = 6;
    reset = 1'b1;
    #1;
    chk("t6_we", 32'(RegWrite), 0);
    chk("t6_wreg", 32'(Write_register), 0);
    chk("t6_wdata", Write_data, 0);
    chk("t6_count", 32'(Count), 0);
    chk("t6_ready", 32'(In_ready), 1);
    chk("t6_haz", 32'(Hazard1), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_write", 32'(RegWrite), 0);
    end
    chk("t6_count_end", 32'(Count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
